mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage between the XM pipeline register and the MW pipeline register.
- Decodes the XM instruction. Loads and stores run a req/ack handshake against data memory, and the pipeline stalls until the access completes.
- Produces the mw_aluin, mw_datain and mw_irin inputs plus the write enable for the MW register.

Parameters:
ADDR_W, 12, data memory word-address width; the address is xm_alu[ADDR_W-1:0].
TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort; used only with MEM_TIMEOUT_EN.

Ports:
clock  input  1  single system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
xm_alu  input  32  ALU result from XM; memory address for lw/sw.
xm_b  input  32  store data from XM.
xm_ir  input  32  instruction from XM.
dmem_req  output  1  registered memory request.
dmem_we  output  1  registered write strobe, high for sw.
dmem_addr  output  ADDR_W  registered word address.
dmem_wdata  output  32  registered store data.
dmem_rdata  input  32  load data, valid when dmem_ack is high.
dmem_ack  input  1  one-cycle completion pulse from memory.
mw_aluin  output  32  to MW register.
mw_datain  output  32  to MW register.
mw_irin  output  32  to MW register.
mw_write_enable  output  1  MW register write enable.
stall  output  1  freezes PC/FD/DX/XM while high.
mem_fault  output  1  sticky timeout flag.

Behaviour:
- Opcode decode:
  - xm_ir[31:27]=00111 is sw; 01000 is lw.
  - Every other opcode, including xm_ir=0 (nop), is non-memory.
- States: IDLE, ACCESS, DONE. Reset state is IDLE.
- Reset values:
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, load latch=0, mem_fault=0.
  - While reset is high, stall=0 and mw_write_enable=0, both forced combinationally.
- IDLE, non-memory op:
  - stall=0, mw_write_enable=1, mw_datain=0.
  - Pass-through in the same cycle; no added latency.
- IDLE, lw/sw:
  - stall=1, mw_write_enable=0.
  - Capture addr, wdata and we (we=1 for sw); set dmem_req=1; go to ACCESS.
  - The request is visible on the next cycle.
- ACCESS:
  - stall=1, mw_write_enable=0; dmem_req held high.
  - On dmem_ack: drop dmem_req and dmem_we on that edge, latch dmem_rdata (lw only), go to DONE.
  - An ack in the first ACCESS cycle is legal.
- DONE:
  - stall=0, mw_write_enable=1.
  - mw_datain = latch for lw, 0 for sw.
  - Next state is IDLE unconditionally.
  - A back-to-back memory op enters IDLE and launches on the following cycle.
- Minimum memory-op latency is 3 cycles, from arrival to MW write.
- Field routing: mw_aluin=xm_alu and mw_irin=xm_ir in all states.
- Upstream contract: XM outputs stay stable while stall=1.
- dmem_ack outside ACCESS is ignored.
- Address above 2^ADDR_W is truncated; there is no range check.
- Reset mid-access: FSM returns to IDLE and dmem_req drops asynchronously. A late ack after reset is ignored.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - An 8-bit watchdog counts ACCESS cycles and clears on entry to ACCESS.
  - If it reaches TIMEOUT_CYCLES with no ack: drop dmem_req, go to DONE, force mw_irin=0 and mw_datain=0 for that cycle (nop injected).
  - mem_fault is set and stays high until reset.
- Undefined:
  - No counter; ACCESS waits indefinitely.
  - mem_fault is tied to 0 and TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package proc_pkg holds:
  - opcode constants OP_SW=5'b00111 and OP_LW=5'b01000;
  - the opcode field bounds [31:27];
  - the 2-bit state encodings IDLE=0, ACCESS=1, DONE=2.
- One sub-module, dmem_watchdog (counter plus compare, producing a timeout pulse), instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- add (opcode 00000) with xm_alu=0x1234 -> same cycle: stall=0, mw_write_enable=1, mw_aluin=0x1234, mw_datain=0.
- sw with xm_alu=0x005, xm_b=0xDEADBEEF, ack 2 cycles after req:
  - dmem_addr=0x005, dmem_we=1, wdata=0xDEADBEEF;
  - stall high 3 cycles, then DONE with mw_datain=0.
- lw with addr 0x0A0, memory returns 0xCAFEF00D with ack in the first ACCESS cycle -> DONE cycle mw_datain=0xCAFEF00D; total latency 3 cycles.
- lw then immediately sw -> two separate req pulses; IDLE appears between them; no overlapping requests.
- reset asserted during ACCESS -> dmem_req=0 asynchronously; later ack ignored; next nop passes with stall=0.
- MEM_TIMEOUT_EN, ack withheld -> after 16 ACCESS cycles: DONE with mw_irin=0, mem_fault=1 and sticky until reset.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared pipeline definitions: memory opcodes, opcode field bounds and
// the memory-stage state encoding.
package proc_pkg;

  localparam logic [4:0] OP_SW = 5'b00111;
  localparam logic [4:0] OP_LW = 5'b01000;

  localparam int OP_HI = 31;
  localparam int OP_LO = 27;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

endpackage

// File: rtl/dmem_watchdog.sv
// Access watchdog for mem_stage: pulses timeout on the TIMEOUT_CYCLES-th
// ACCESS cycle. Only built when MEM_TIMEOUT_EN is defined.
`ifdef MEM_TIMEOUT_EN
module dmem_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic active,
  output logic timeout
);

  logic [7:0] cnt;

  // Reloaded on entry to ACCESS, so the terminal count lands on the last allowed cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= 8'd0;
    end else if (start) begin
      cnt <= 8'(TIMEOUT_CYCLES - 1);
    end else if (active && cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign timeout = active && (cnt == 8'd0);

endmodule
`endif

// File: rtl/mem_stage.sv
// Memory-access stage between XM and MW: runs the dmem req/ack handshake and
// stalls upstream until it completes. MEM_TIMEOUT_EN adds an access watchdog.
//
// state  | meaning
// IDLE   | pass-through; a lw/sw launches a request
// ACCESS | request outstanding, waiting for dmem_ack
// DONE   | access finished, MW register written
module mem_stage
  import proc_pkg::*;
#(
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       xm_alu,
  input  logic [31:0]       xm_b,
  input  logic [31:0]       xm_ir,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic [31:0]       mw_aluin,
  output logic [31:0]       mw_datain,
  output logic [31:0]       mw_irin,
  output logic              mw_write_enable,
  output logic              stall,
  output logic              mem_fault
);

  mem_state_t  state, next_state;
  logic [4:0]  opcode;
  logic        is_lw, is_sw, is_mem;
  logic [31:0] load_q;
  logic        timeout;

  assign opcode = xm_ir[OP_HI:OP_LO];
  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);
  assign is_mem = is_lw || is_sw;

`ifdef MEM_TIMEOUT_EN
  logic timed_out_q;

  dmem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .start   (state == IDLE && is_mem),
    .active  (state == ACCESS),
    .timeout (timeout)
  );

  // An ack arriving on the timeout cycle still wins; only a true miss faults.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timed_out_q <= 1'b0;
      mem_fault   <= 1'b0;
    end else begin
      timed_out_q <= (state == ACCESS) && timeout && !dmem_ack;
      if ((state == ACCESS) && timeout && !dmem_ack) mem_fault <= 1'b1;
    end
  end
`else
  logic [7:0] unused_tmo;
  assign unused_tmo = 8'(TIMEOUT_CYCLES);
  assign timeout    = 1'b0;
  assign mem_fault  = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (is_mem) next_state = ACCESS;
      ACCESS:  if (dmem_ack || timeout) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= 32'd0;
      load_q     <= 32'd0;
    end else if (state == IDLE && is_mem) begin
      dmem_req   <= 1'b1;
      dmem_we    <= is_sw;
      dmem_addr  <= xm_alu[ADDR_W-1:0];
      dmem_wdata <= xm_b;
    end else if (state == ACCESS && (dmem_ack || timeout)) begin
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      if (dmem_ack && is_lw) load_q <= dmem_rdata;
    end
  end

  assign mw_aluin = xm_alu;

  always_comb begin
    stall           = 1'b0;
    mw_write_enable = 1'b0;
    mw_datain       = 32'd0;
    mw_irin         = xm_ir;
    if (!reset) begin
      case (state)
        IDLE: begin
          stall           = is_mem;
          mw_write_enable = !is_mem;
        end
        ACCESS: stall = 1'b1;
        DONE: begin
          mw_write_enable = 1'b1;
          if (is_lw) mw_datain = load_q;
        end
        default: ;
      endcase
    end
`ifdef MEM_TIMEOUT_EN
    // A timed-out access retires as a nop.
    if (state == DONE && timed_out_q) begin
      mw_irin   = 32'd0;
      mw_datain = 32'd0;
    end
`endif
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; the timeout scenario adapts to
// whether MEM_TIMEOUT_EN is defined.
module tb_mem_stage;

  localparam int          ADDR_W = 12;
  localparam logic [31:0] IR_SW  = 32'h3800_0000;
  localparam logic [31:0] IR_LW  = 32'h4000_0000;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       xm_alu = 32'd0, xm_b = 32'd0, xm_ir = 32'd0;
  logic              dmem_req, dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata = 32'd0;
  logic              dmem_ack = 1'b0;
  logic [31:0]       mw_aluin, mw_datain, mw_irin;
  logic              mw_write_enable, stall, mem_fault;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mem_stage #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .xm_alu(xm_alu), .xm_b(xm_b), .xm_ir(xm_ir),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mw_aluin(mw_aluin), .mw_datain(mw_datain), .mw_irin(mw_irin),
    .mw_write_enable(mw_write_enable), .stall(stall), .mem_fault(mem_fault)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    xm_ir = IR_LW; xm_alu = 32'h55; dmem_ack = 1'b1;
    step(); step(); #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", dmem_req); end
    checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL rst_we got=%b exp=0", dmem_we); end
    checks++; if (dmem_addr !== 12'h000) begin errors++; $display("FAIL rst_addr got=%h exp=000", dmem_addr); end
    checks++; if (dmem_wdata !== 32'd0) begin errors++; $display("FAIL rst_wdata got=%h exp=0", dmem_wdata); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", stall); end
    checks++; if (mw_write_enable !== 1'b0) begin errors++; $display("FAIL rst_mwe got=%b exp=0", mw_write_enable); end
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL rst_fault got=%b exp=0", mem_fault); end
    xm_ir = 32'd0; dmem_ack = 1'b0;
    @(negedge clock); reset = 1'b0;
    step();
  endtask

  task automatic test_passthrough();
    xm_ir = 32'h0012_3400; xm_alu = 32'h1234; xm_b = 32'h9999; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nop_stall got=%b exp=0", stall); end
    checks++; if (mw_write_enable !== 1'b1) begin errors++; $display("FAIL nop_mwe got=%b exp=1", mw_write_enable); end
    checks++; if (mw_aluin !== 32'h1234) begin errors++; $display("FAIL nop_aluin got=%h exp=00001234", mw_aluin); end
    checks++; if (mw_datain !== 32'd0) begin errors++; $display("FAIL nop_datain got=%h exp=0", mw_datain); end
    checks++; if (mw_irin !== 32'h0012_3400) begin errors++; $display("FAIL nop_irin got=%h exp=00123400", mw_irin); end
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    step();
    dmem_ack = 1'b0; #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL idle_ack_req got=%b exp=0", dmem_req); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL idle_ack_stall got=%b exp=0", stall); end
    xm_ir = 32'h4800_0000; #1;
    checks++; if (stall !== 1'b0 || mw_write_enable !== 1'b1) begin errors++; $display("FAIL op01001 got stall=%b mwe=%b exp stall=0 mwe=1", stall, mw_write_enable); end
    xm_ir = 32'h3000_0000; #1;
    checks++; if (stall !== 1'b0 || mw_write_enable !== 1'b1) begin errors++; $display("FAIL op00110 got stall=%b mwe=%b exp stall=0 mwe=1", stall, mw_write_enable); end
    step();
  endtask

  task automatic test_sw();
    int n_stall;
    xm_ir = IR_SW | 32'h0000_0042; xm_alu = 32'h005; xm_b = 32'hDEAD_BEEF; #1;
    n_stall = 0;
    checks++; if (stall !== 1'b1 || mw_write_enable !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL sw_c0 got stall=%b mwe=%b req=%b exp 1 0 0", stall, mw_write_enable, dmem_req); end
    if (stall) n_stall++;
    step();
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin errors++; $display("FAIL sw_req got req=%b we=%b exp 1 1", dmem_req, dmem_we); end
    checks++; if (dmem_addr !== 12'h005) begin errors++; $display("FAIL sw_addr got=%h exp=005", dmem_addr); end
    checks++; if (dmem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wdata got=%h exp=deadbeef", dmem_wdata); end
    if (stall) n_stall++;
    step();
    dmem_ack = 1'b1; #1;
    checks++; if (dmem_req !== 1'b1 || mw_write_enable !== 1'b0) begin errors++; $display("FAIL sw_hold got req=%b mwe=%b exp 1 0", dmem_req, mw_write_enable); end
    if (stall) n_stall++;
    step();
    dmem_ack = 1'b0; #1;
    checks++; if (n_stall !== 3) begin errors++; $display("FAIL sw_stall_cycles got=%0d exp=3", n_stall); end
    checks++; if (stall !== 1'b0 || mw_write_enable !== 1'b1) begin errors++; $display("FAIL sw_done got stall=%b mwe=%b exp 0 1", stall, mw_write_enable); end
    checks++; if (mw_datain !== 32'd0) begin errors++; $display("FAIL sw_datain got=%h exp=0", mw_datain); end
    checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin errors++; $display("FAIL sw_drop got req=%b we=%b exp 0 0", dmem_req, dmem_we); end
    step();
    xm_ir = 32'd0; #1;
    checks++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL sw_after got req=%b stall=%b exp 0 0", dmem_req, stall); end
    step();
  endtask

  task automatic test_lw();
    xm_ir = IR_LW; xm_alu = 32'h0A0; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lw_c0_stall got=%b exp=1", stall); end
    step();
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D; #1;
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 12'h0A0) begin errors++; $display("FAIL lw_req got req=%b we=%b addr=%h exp 1 0 0a0", dmem_req, dmem_we, dmem_addr); end
    step();
    dmem_ack = 1'b0; dmem_rdata = 32'h0; #1;
    checks++; if (stall !== 1'b0 || mw_write_enable !== 1'b1) begin errors++; $display("FAIL lw_done got stall=%b mwe=%b exp 0 1", stall, mw_write_enable); end
    checks++; if (mw_datain !== 32'hCAFE_F00D) begin errors++; $display("FAIL lw_datain got=%h exp=cafef00d", mw_datain); end
    checks++; if (mw_irin !== IR_LW) begin errors++; $display("FAIL lw_irin got=%h exp=%h", mw_irin, IR_LW); end
  endtask

  // Entered from the DONE cycle of test_lw: the next XM op is a sw.
  task automatic test_back_to_back();
    step();
    xm_ir = IR_SW; xm_alu = 32'h0001_2345; xm_b = 32'h1111_2222; #1;
    checks++; if (dmem_req !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL b2b_gap got req=%b stall=%b exp 0 1", dmem_req, stall); end
    step();
    dmem_ack = 1'b1; #1;
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 12'h345) begin errors++; $display("FAIL b2b_req got req=%b we=%b addr=%h exp 1 1 345", dmem_req, dmem_we, dmem_addr); end
    step();
    dmem_ack = 1'b0; #1;
    checks++; if (mw_write_enable !== 1'b1 || mw_datain !== 32'd0 || dmem_req !== 1'b0) begin errors++; $display("FAIL b2b_done got mwe=%b datain=%h req=%b exp 1 0 0", mw_write_enable, mw_datain, dmem_req); end
    step();
    xm_ir = 32'd0;
    step();
  endtask

  task automatic test_reset_mid_access();
    xm_ir = IR_LW; xm_alu = 32'h77; #1;
    step(); #1;
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL mid_req got=%b exp=1", dmem_req); end
    reset = 1'b1; xm_ir = 32'd0; #1;
    checks++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL mid_async got req=%b stall=%b exp 0 0", dmem_req, stall); end
    @(negedge clock); reset = 1'b0;
    step();
    dmem_ack = 1'b1; dmem_rdata = 32'h1357_9BDF; #1;
    checks++; if (stall !== 1'b0 || mw_write_enable !== 1'b1) begin errors++; $display("FAIL mid_nop got stall=%b mwe=%b exp 0 1", stall, mw_write_enable); end
    step();
    dmem_ack = 1'b0; #1;
    checks++; if (dmem_req !== 1'b0 || stall !== 1'b0 || mw_datain !== 32'd0) begin errors++; $display("FAIL mid_late_ack got req=%b stall=%b datain=%h exp 0 0 0", dmem_req, stall, mw_datain); end
    step();
  endtask

  task automatic test_timeout();
    int n;
    xm_ir = IR_LW | 32'h0000_0ABC; xm_alu = 32'h0C0; #1;
    step();
    n = 0;
    while (stall === 1'b1 && n < 40) begin
      n++;
      step();
    end
`ifdef MEM_TIMEOUT_EN
    checks++; if (n !== 16) begin errors++; $display("FAIL tmo_cycles got=%0d exp=16", n); end
    checks++; if (mw_irin !== 32'd0 || mw_datain !== 32'd0 || mw_write_enable !== 1'b1) begin errors++; $display("FAIL tmo_done got irin=%h datain=%h mwe=%b exp 0 0 1", mw_irin, mw_datain, mw_write_enable); end
    checks++; if (mem_fault !== 1'b1 || dmem_req !== 1'b0) begin errors++; $display("FAIL tmo_fault got fault=%b req=%b exp 1 0", mem_fault, dmem_req); end
    step();
    xm_ir = 32'd0;
    step(); step();
    checks++; if (mem_fault !== 1'b1) begin errors++; $display("FAIL tmo_sticky got=%b exp=1", mem_fault); end
`else
    checks++; if (n !== 40 || dmem_req !== 1'b1) begin errors++; $display("FAIL wait_forever got n=%0d req=%b exp 40 1", n, dmem_req); end
    checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL no_fault got=%b exp=0", mem_fault); end
`endif
    reset = 1'b1; xm_ir = 32'd0; #1;
    @(negedge clock); reset = 1'b0;
    step();
    checks++; if (mem_fault !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL tmo_clear got fault=%b stall=%b exp 0 0", mem_fault, stall); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_sw();
    test_lw();
    test_back_to_back();
    test_reset_mid_access();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
